// File: rtl/maxhpc_fifo_fwft.sv
// First-word-fall-through FIFO controller driving an external dual-port RAM with registered read.
// Optional watermark flags are enabled by defining MAXHPC_FIFO_WATERMARK_EN.
module maxhpc_fifo_fwft #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 8,
  parameter int AF_LVL  = 4,
  parameter int AE_LVL  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_WD-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_WD-1:0] out_data,
  output logic [ADDR_WD+1:0] level,
  output logic               ram_a_ce,
  output logic               ram_a_we,
  output logic [ADDR_WD-1:0] ram_a_addr,
  output logic [DATA_WD-1:0] ram_a_d,
  output logic               ram_b_ce,
  output logic [ADDR_WD-1:0] ram_b_addr,
  input  logic [DATA_WD-1:0] ram_b_q
`ifdef MAXHPC_FIFO_WATERMARK_EN
  ,
  output logic               almost_full,
  output logic               almost_empty
`endif
);

  localparam int CW = ADDR_WD + 1;
  localparam int LW = ADDR_WD + 2;
  localparam logic [ADDR_WD:0] DEPTH_C = {1'b1, {ADDR_WD{1'b0}}};

  logic [ADDR_WD-1:0] wr_ptr_reg;
  logic [ADDR_WD-1:0] rd_ptr_reg;
  logic [ADDR_WD:0]   mem_cnt_reg;
  logic [ADDR_WD:0]   mem_cnt_next;
  logic               inflight_reg;
  logic [1:0]         obuf_cnt_reg;
  logic [1:0]         obuf_cnt_next;
  logic [DATA_WD-1:0] obuf0_reg;
  logic [DATA_WD-1:0] obuf1_reg;
  logic [2:0]         occ;
  logic               push;
  logic               pop;
  logic               issue;

  assign in_ready  = (mem_cnt_reg != DEPTH_C);
  assign out_valid = (obuf_cnt_reg != 2'd0);
  assign out_data  = obuf0_reg;

  // Gating with rst_n keeps the RAM write port quiet while reset is held.
  assign push = in_valid & in_ready & rst_n;
  assign pop  = out_valid & out_ready;

  // Buffer slots already claimed once this cycle's pop is accounted for.
  assign occ   = {1'b0, obuf_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue = (mem_cnt_reg != '0) && (occ < 3'd2);

  assign mem_cnt_next  = mem_cnt_reg + CW'(push) - CW'(issue);
  assign obuf_cnt_next = obuf_cnt_reg + 2'(inflight_reg) - 2'(pop);

  assign level = LW'(mem_cnt_reg) + LW'(inflight_reg) + LW'(obuf_cnt_reg);

  assign ram_a_ce   = push;
  assign ram_a_we   = push;
  assign ram_a_addr = wr_ptr_reg;
  assign ram_a_d    = in_data;
  assign ram_b_ce   = issue;
  assign ram_b_addr = rd_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      mem_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      obuf_cnt_reg <= 2'd0;
      obuf0_reg    <= '0;
      obuf1_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      mem_cnt_reg  <= mem_cnt_next;
      inflight_reg <= issue;
      obuf_cnt_reg <= obuf_cnt_next;
      // Head leaves on pop; a word returning from the RAM is appended behind what remains.
      if (pop) begin
        if (inflight_reg && obuf_cnt_reg == 2'd2) begin
          obuf0_reg <= obuf1_reg;
          obuf1_reg <= ram_b_q;
        end else if (inflight_reg) begin
          obuf0_reg <= ram_b_q;
        end else begin
          obuf0_reg <= obuf1_reg;
        end
      end else if (inflight_reg) begin
        if (obuf_cnt_reg == 2'd0) obuf0_reg <= ram_b_q;
        else obuf1_reg <= ram_b_q;
      end
    end
  end

`ifdef MAXHPC_FIFO_WATERMARK_EN
  logic [ADDR_WD+1:0] level_next;
  logic               almost_full_reg;
  logic               almost_empty_reg;

  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      almost_full_reg  <= (level_next >= LW'((2 ** ADDR_WD) + 2 - AF_LVL));
      almost_empty_reg <= (level_next <= LW'(AE_LVL));
    end
  end

  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
`endif

endmodule

// File: tb/tb_maxhpc_fifo_fwft.sv
// Directed bench for maxhpc_fifo_fwft with a behavioural registered-read RAM and a queue scoreboard.
module tb_maxhpc_fifo_fwft;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          ram_a_ce;
  logic          ram_a_we;
  logic [AW-1:0] ram_a_addr;
  logic [DW-1:0] ram_a_d;
  logic          ram_b_ce;
  logic [AW-1:0] ram_b_addr;
  logic [DW-1:0] ram_b_q;
`ifdef MAXHPC_FIFO_WATERMARK_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  maxhpc_fifo_fwft #(.ADDR_WD(AW), .DATA_WD(DW), .AF_LVL(4), .AE_LVL(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .ram_a_ce   (ram_a_ce),
    .ram_a_we   (ram_a_we),
    .ram_a_addr (ram_a_addr),
    .ram_a_d    (ram_a_d),
    .ram_b_ce   (ram_b_ce),
    .ram_b_addr (ram_b_addr),
    .ram_b_q    (ram_b_q)
`ifdef MAXHPC_FIFO_WATERMARK_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM, registered read on port B.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (ram_a_ce && ram_a_we) ram[ram_a_addr] <= ram_a_d;
    if (ram_b_ce) ram_b_q <= ram[ram_b_addr];
  end

  int total = 0;
  int bad = 0;
  int tot_push = 0;
  int tot_pop = 0;
  logic [DW-1:0] q[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: sample handshakes, update scoreboard, advance to 1ns after the edge.
  task automatic tick();
    logic p;
    logic o;
    #1;
    p = in_valid & in_ready;
    o = out_valid & out_ready;
    chk("level", 32'(level), 32'(q.size()));
    if (prev_stall) chk("hold", 32'(out_data), 32'(prev_data));
    if (o) begin
      if (q.size() == 0) chk("pop_empty", 32'(out_valid), 32'd0);
      else begin
        chk("pop_data", 32'(out_data), 32'(q.pop_front()));
        tot_pop++;
      end
    end
    if (p) begin
      q.push_back(in_data);
      tot_push++;
    end
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    chk("drain_level", 32'(level), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int base;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_ce", 32'(ram_a_ce), 32'd0);
    chk("rst_b_ce", 32'(ram_b_ce), 32'd0);
`ifdef MAXHPC_FIFO_WATERMARK_EN
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // Single word latency: push at t, issue at t+1, visible at t+3.
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    chk("t0_a_ce", 32'(ram_a_ce), 32'd1);
    chk("t0_a_addr", 32'(ram_a_addr), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_b_ce", 32'(ram_b_ce), 32'd1);
    chk("t1_b_addr", 32'(ram_b_addr), 32'd0);
    tick();
    chk("t2_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    chk("t3_out_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick();
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Fill to DEPTH+2 with the consumer stalled.
    base = tot_push;
    for (int i = 0; i < 22; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(tot_push - base);
      tick();
    end
    chk("full_accepted", 32'(tot_push - base), 32'd18);
    chk("full_level", 32'(level), 32'd18);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #1;
    chk("full_a_ce", 32'(ram_a_ce), 32'd0);
    chk("full_wr_ptr", 32'(ram_a_addr), 32'd3); // 1 + 18 words, mod 16
    drain();

    // Continuous stream: one word per cycle, level pinned at 3 once primed.
    for (int k = 0; k < 100; k++) begin
      in_valid  = 1'b1;
      in_data   = 8'(k);
      out_ready = 1'b1;
      tick();
      if (k >= 2) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_level", 32'(level), 32'd3);
      end
    end
    drain();

    // Random handshakes across many pointer wraps.
    base = tot_pop;
    cyc = 0;
    while ((tot_pop - base) < 2000 && cyc < 20000) begin
      in_valid  = (tot_push - base < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!(in_valid && !in_ready)) in_data = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("rand_done", 32'(tot_pop - base), 32'd2000);
    drain();

    // Asynchronous reset with 7 words held.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h70 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h3C);
    drain();

`ifdef MAXHPC_FIFO_WATERMARK_EN
    // Watermarks: almost_full at 14 words, almost_empty at 2 or fewer.
    for (int n = 1; n <= 14; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(n);
      tick();
      chk("wm_af_fill", 32'(almost_full), 32'(n >= 14));
      chk("wm_ae_fill", 32'(almost_empty), 32'(n <= 2));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      tick();
      chk("wm_af_drain", 32'(almost_full), 32'(q.size() >= 14));
      chk("wm_ae_drain", 32'(almost_empty), 32'(q.size() <= 2));
    end
    out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxhpc_fifo_fwft.md
Name: maxhpc_fifo_fwft

Overview:
Single-clock first-word-fall-through FIFO controller that drives an external dual-port block RAM.
- Port A of the RAM is used for writes only; port B for reads only.
- The RAM has a registered read: q is valid 1 cycle after a ce-qualified address.
- The block hides this latency behind a 2-entry output buffer and exposes valid/ready streams on both sides.
- Sits between a producer (DMA/UART/packet source) and its consumer.

Parameters:
ADDR_WD, 8, RAM address width; RAM depth DEPTH = 2**ADDR_WD.
DATA_WD, 8, word width.
AF_LVL, 4, almost-full margin: asserted when level >= DEPTH+2-AF_LVL (feature only).
AE_LVL, 2, almost-empty threshold: asserted when level <= AE_LVL (feature only).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  producer word valid
in_ready  out  1  FIFO can accept a word
in_data  in  DATA_WD  producer word
out_valid  out  1  head word valid
out_ready  in  1  consumer accepts head word
out_data  out  DATA_WD  head word
level  out  ADDR_WD+2  total words held (RAM + in-flight + output buffer)
ram_a_ce  out  1  RAM port A enable (= push)
ram_a_we  out  1  RAM port A write (= push)
ram_a_addr  out  ADDR_WD  write pointer
ram_a_d  out  DATA_WD  = in_data
ram_b_ce  out  1  RAM port B read issue
ram_b_addr  out  ADDR_WD  read pointer
ram_b_q  in  DATA_WD  RAM read data, valid 1 cycle after ram_b_ce
almost_full  out  1  feature only
almost_empty  out  1  feature only

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, mem_cnt=0, inflight=0, obuf_cnt=0.
  - Outputs during reset: out_valid=0, level=0, in_ready=1, ram_*_ce=0.
  - Reset mid-operation discards all contents; RAM contents are ignored.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (mem_cnt != DEPTH). It is a registered-state function and never depends on out_ready.
- Push: RAM write at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Read issue: ram_b_ce = (mem_cnt != 0) & (obuf_cnt + inflight - pop < 2).
  - On issue, rd_ptr increments (wraps) and inflight is set for 1 cycle.
  - mem_cnt counts RAM words not yet issued: next = mem_cnt + push - ram_b_ce.
- Capture: the cycle after an issue, ram_b_q is written into the 2-entry output buffer (ordered, head first).
- out_data = buffer head; out_valid = (obuf_cnt != 0).
  - A pop and a capture in the same cycle are both legal: head advances and the new word is appended.
- Read and write never target the same RAM address in one cycle: a read requires mem_cnt != 0, and a write requires mem_cnt != DEPTH.
- Latency: push in cycle t on an empty FIFO -> out_valid=1 in cycle t+3.
- Throughput: 1 word/cycle sustained in both directions once primed.
- level = mem_cnt + inflight + obuf_cnt; maximum DEPTH+2.
- Full: in_ready=0 when mem_cnt=DEPTH; in_valid is ignored and the pointers hold.
- Empty: out_valid=0; out_ready is ignored and no pop occurs.
- Simultaneous push & pop at any level: level is unchanged.
- out_data holds a stable value while out_valid=1 and out_ready=0.

Optional Feature:
MAXHPC_FIFO_WATERMARK_EN
- Defined: almost_full and almost_empty ports exist and are registered, updated from next-level.
  - almost_full = (level >= DEPTH+2-AF_LVL); almost_empty = (level <= AE_LVL).
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: both ports and their logic are absent; AF_LVL and AE_LVL are unused.

Test Plan:
- Reset, then single push of 0xA5 at cycle t -> ram_b_ce at t+1, out_valid=1 with out_data=0xA5 at t+3; pop -> level 0, out_valid=0.
- ADDR_WD=4, push 0x00..0x11 (18 words) with out_ready=0 -> in_ready drops after 18 accepted, level=18; further in_valid ignored; then drain -> 0x00..0x11 in order.
- Continuous push and pop (out_ready=1) of an incrementing stream, 100 words -> after priming, one word per cycle, no gaps, no reorder, level constant at 3.
- Random in_valid/out_ready (50%) over 2000 words with pointer wrap -> scoreboard matches exactly; out_data stable while stalled.
- Assert rst_n=0 mid-stream with level=7 -> out_valid=0, level=0, in_ready=1 immediately; post-reset push 0x3C is the first word out.
- With MAXHPC_FIFO_WATERMARK_EN, ADDR_WD=4: fill to level 14 -> almost_full=1 (AF_LVL=4); drain to level 2 -> almost_empty=1.
